// File: rtl/pipeline_ctrl_if.sv
// Decode-stage <-> pipeline controller signal bundle: ID instruction info in, stage enables/flushes out.
// Handshake-free: every signal is level-valid in the cycle it is driven; there is no valid/ready pair.
interface pipeline_ctrl_if;
    logic [4:0] rs1_addr_id;
    logic [4:0] rs2_addr_id;
    logic [4:0] rd0_addr_id;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd0_wr_en_id;
    logic       data_rd_en_id;
    logic       data_wr_en_id;
    logic       cond_jump;
    logic       jalr;
    logic       branch_taken;
    logic       dmem_ready;

    logic       pc_en;
    logic       pc_sel;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       pipe_en;
    logic [1:0] jmp_src1;
    logic [1:0] jmp_src2;
    logic       mem_err;

    // Controller side: sole source of enables, flushes and forward selects.
    modport master (
        input  rs1_addr_id, rs2_addr_id, rd0_addr_id, rs1_used, rs2_used, rd0_wr_en_id,
               data_rd_en_id, data_wr_en_id, cond_jump, jalr, branch_taken, dmem_ready,
        output pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, pipe_en, jmp_src1, jmp_src2, mem_err
    );

    modport slave (
        output rs1_addr_id, rs2_addr_id, rd0_addr_id, rs1_used, rs2_used, rd0_wr_en_id,
               data_rd_en_id, data_wr_en_id, cond_jump, jalr, branch_taken, dmem_ready,
        input  pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, pipe_en, jmp_src1, jmp_src2, mem_err
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the five-stage core: shadow scoreboard of EX/MA/WB destinations,
// jump-operand forward selects, load-use and branch-on-load stalls, taken-branch flush and memory freeze.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.master   bus,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] RD_ID = 2'd0;
    localparam logic [1:0] RD_EX = 2'd1;
    localparam logic [1:0] RD_MA = 2'd2;
    localparam logic [1:0] RD_WB = 2'd3;

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       mem;
    } sb_entry_t;

    state_e      state, state_nxt;
    sb_entry_t   sb_ex, sb_ma, sb_wb, id_entry;
    logic [15:0] wait_cnt, wait_nxt;
    logic        mem_err_q;

    logic        need1, need2, haz, frz;
    logic        m1_ex, m1_ma, m1_wb, m2_ex, m2_ma, m2_wb;
    logic        pc_en_w, pc_sel_w, ifid_en_w, ifid_flush_w, idex_flush_w, pipe_en_w;
    logic [1:0]  src1_w, src2_w;

    function automatic logic hit(input sb_entry_t e, input logic [4:0] src);
        return e.wr && (e.rd != 5'd0) && (e.rd == src);
    endfunction

    assign id_entry = '{rd:  bus.rd0_addr_id,
                        wr:  bus.rd0_wr_en_id,
                        ld:  bus.data_rd_en_id,
                        mem: bus.data_rd_en_id | bus.data_wr_en_id};

    assign need1 = bus.cond_jump | bus.jalr;
    assign need2 = bus.cond_jump;

    assign m1_ex = hit(sb_ex, bus.rs1_addr_id);
    assign m1_ma = hit(sb_ma, bus.rs1_addr_id);
    assign m1_wb = hit(sb_wb, bus.rs1_addr_id);
    assign m2_ex = hit(sb_ex, bus.rs2_addr_id);
    assign m2_ma = hit(sb_ma, bus.rs2_addr_id);
    assign m2_wb = hit(sb_wb, bus.rs2_addr_id);

    // Load data only exists at WB, so a jump source hitting a load in EX or MA must wait.
    assign haz = (need1 & ((m1_ex & sb_ex.ld) | (m1_ma & sb_ma.ld)))
               | (need2 & ((m2_ex & sb_ex.ld) | (m2_ma & sb_ma.ld)))
               | (bus.rs1_used & m1_ex & sb_ex.ld)
               | (bus.rs2_used & m2_ex & sb_ex.ld);

    assign frz = sb_ma.mem & ~bus.dmem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:     state_nxt = RUN;
            RUN:      if (frz) state_nxt = MEM_WAIT;
            MEM_WAIT: if (!frz) state_nxt = RUN;
            default:  state_nxt = INIT;
        endcase
    end

    always_comb begin
        src1_w       = RD_ID;
        src2_w       = RD_ID;
        pipe_en_w    = ~frz;
        pc_en_w      = ~frz & ~haz;
        ifid_en_w    = ~frz & ~haz;
        idex_flush_w = ~frz & haz;
        pc_sel_w     = bus.branch_taken & pc_en_w;
        ifid_flush_w = pc_sel_w;

        if (need1) begin
            if (m1_ex)      src1_w = RD_EX;
            else if (m1_ma) src1_w = RD_MA;
            else if (m1_wb) src1_w = RD_WB;
        end
        if (need2) begin
            if (m2_ex)      src2_w = RD_EX;
            else if (m2_ma) src2_w = RD_MA;
            else if (m2_wb) src2_w = RD_WB;
        end

        // Reset and the post-reset INIT cycle both squash IF/ID and EX while letting the back end drain.
        if (rst || state == INIT) begin
            pipe_en_w    = 1'b1;
            pc_en_w      = 1'b0;
            ifid_en_w    = 1'b0;
            idex_flush_w = 1'b1;
            pc_sel_w     = 1'b0;
            ifid_flush_w = 1'b1;
        end
        if (rst) begin
            src1_w = RD_ID;
            src2_w = RD_ID;
        end
    end

    // First frozen cycle (still in RUN) counts as wait cycle 1; saturate instead of wrapping.
    assign wait_nxt = (state == MEM_WAIT) ? ((wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1)
                                          : 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sb_ex     <= '0;
            sb_ma     <= '0;
            sb_wb     <= '0;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pipe_en_w) begin
                sb_ex <= idex_flush_w ? '0 : id_entry;
                sb_ma <= sb_ex;
                sb_wb <= sb_ma;
            end
            if (frz && state != INIT) begin
                wait_cnt <= wait_nxt;
                if (wait_nxt == TIMEOUT) mem_err_q <= 1'b1;
            end
        end
    end

    assign bus.pc_en      = pc_en_w;
    assign bus.pc_sel     = pc_sel_w;
    assign bus.ifid_en    = ifid_en_w;
    assign bus.ifid_flush = ifid_flush_w;
    assign bus.idex_flush = idex_flush_w;
    assign bus.pipe_en    = pipe_en_w;
    assign bus.jmp_src1   = src1_w;
    assign bus.jmp_src2   = src2_w;
    assign bus.mem_err    = mem_err_q;
    assign fsm_state      = state;
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage core. It tracks the destination registers of the instructions in EX, MA and WB in a shadow scoreboard, and uses it to drive the jump-operand forward selects (`jmp_src1`/`jmp_src2`) of the decode stage. It also generates the pipeline enables, bubble insertion and flushes for load-use hazards, taken branches and data-memory wait states. It sits beside the decode stage and is the only source of stage enables and flushes.

## Interface
- `MEM_TIMEOUT`, default 255: MEM_WAIT cycles tolerated before `mem_err` is set (1..65535).
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `rs1_addr_id` in 5: rs1 field of the instruction in ID.
- `rs2_addr_id` in 5: rs2 field of the instruction in ID.
- `rd0_addr_id` in 5: rd field of the instruction in ID.
- `rs1_used`, `rs2_used` in 1 each: the ID instruction reads rs1/rs2.
- `rd0_wr_en_id` in 1: the ID instruction writes rd.
- `data_rd_en_id`, `data_wr_en_id` in 1 each: the ID instruction is a load/store.
- `cond_jump` in 1: a conditional branch is in ID; it needs rs1 and rs2 resolved in ID.
- `jalr` in 1: JALR is in ID; it needs rs1 resolved in ID.
- `branch_taken` in 1: the jump decision in ID is taken.
- `dmem_ready` in 1: data memory completes the MA access this cycle.
- `pc_en` out 1: PC register update enable.
- `pc_sel` out 1: PC loads `jump_addr` (1) or PC+4 (0).
- `ifid_en` out 1: IF/ID register enable.
- `ifid_flush` out 1: IF/ID register loads a NOP.
- `idex_flush` out 1: drives the ID/EX `flush`, inserting a bubble into EX.
- `pipe_en` out 1: `clk_en` for the EX, MA and WB registers and the register file.
- `jmp_src1`, `jmp_src2` out 2: ctrlCJmpSrc_e, one of RD_ID/RD_EX/RD_MA/RD_WB.
- `mem_err` out 1: sticky flag, set on MEM_WAIT timeout.

## Operation
- **Scoreboard.** Three entries, EX, MA and WB. Each holds {rd[4:0], wr, ld, mem}.
  - When `pipe_en`=1: EX loads the ID info, or a cleared entry if `idex_flush`=1. MA loads EX, and WB loads MA.
  - When `pipe_en`=0: all entries hold.
  - An entry matches a source register when wr=1, rd≠0 and rd equals the source address. Register x0 never matches.
- **Jump forwarding.** Applies to a source that is needed (rs1 when `cond_jump`|`jalr`; rs2 when `cond_jump`).
  - Priority: EX match → RD_EX, otherwise MA → RD_MA, otherwise WB → RD_WB, otherwise RD_ID.
  - Sources that are not needed select RD_ID.
- **Load data availability.** Load data exists only at WB. `rd0_data_ex` and `rd0_data_ma` carry ALU results.
- **Hazard stall (`haz`).** `haz` is asserted when either condition holds:
  - A needed jump source matches an EX or MA entry with ld=1.
  - A used source (`rs*_used`) matches an EX entry with ld=1 (load-use).
- **Memory freeze (`frz`).** `frz` = MA.mem & !`dmem_ready`.
- **FSM states:**
  - INIT: one cycle after `rst` deasserts. `pc_en`=0, `ifid_flush`=1, `idex_flush`=1, `pipe_en`=1. Always goes to RUN.
  - RUN: normal operation. Goes to MEM_WAIT when `frz`=1.
  - MEM_WAIT: freeze. Goes to RUN in the cycle `dmem_ready`=1; that cycle is already unfrozen.
- **Output equations (RUN/MEM_WAIT):**
  - `pipe_en` = !`frz`.
  - `pc_en` = !`frz` & !`haz`.
  - `ifid_en` = !`frz` & !`haz`.
  - `idex_flush` = !`frz` & `haz`.
  - `pc_sel` = `branch_taken` & `pc_en`.
  - `ifid_flush` = `pc_sel`.
- **Event priority:** `frz` > `haz` > `branch_taken`.
  - A branch resolved during `haz` is ignored; it is re-evaluated once its operands are valid.
  - During `frz`, no flush or bubble is generated and all state holds.
- **Timeout.** A 16-bit wait counter clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
  - When the counter reaches `MEM_TIMEOUT`, `mem_err` is set and stays set until `rst`.
  - The FSM keeps waiting after the timeout.
- **Reset.** `rst` dominates every other input. In the cycle `rst` is high: state=INIT, scoreboard cleared, wait counter=0, `mem_err`=0.

## Timing
- **Output values while `rst`=1:** `pc_en`=0, `pc_sel`=0, `ifid_en`=0, `ifid_flush`=1, `idex_flush`=1, `pipe_en`=1, `jmp_src*`=RD_ID, `mem_err`=0.
- **Combinational outputs.** All outputs except `mem_err` are combinational from state, scoreboard and inputs. `mem_err` is registered.
- **Branch on a load result:**
  - Load in EX: 2 stall cycles.
  - Load in MA: 1 stall cycle.
  - Zero stall cycles once the load is in WB (RD_WB).
- **Branch on an ALU result:** zero stall (RD_EX or RD_MA).
- **Taken branch:** exactly one bubble (IF/ID flush). The redirect takes effect on the next clock edge.
- **Load-use (non-branch):** 1 stall cycle.
- **Freeze length.** A freeze lasts exactly as many cycles as `dmem_ready` is low while MA.mem=1.
- **Reset mid-operation.** Reset takes effect at the next clock edge regardless of state. All pending hazards and MEM_WAIT are discarded.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release → one INIT cycle with `pc_en`=0 and both flushes=1, then RUN with `pc_en`=1 and `pipe_en`=1.
- **Branch on load:** `lw x5` then `beq x5,x6` → 2 cycles with `pc_en`=0 and `idex_flush`=1, then `jmp_src1`=RD_WB and `jmp_src2`=RD_ID. Taken → `pc_sel`=1 and `ifid_flush`=1 for 1 cycle.
- **ALU forward priority:** `add x7`, `add x7`, `jalr x7` → `jmp_src1`=RD_EX (EX beats MA), no stall. A source of `x0` with an x0 destination in EX → RD_ID.
- **Load-use:** `lw x3` then `add x4,x3,x1` → exactly 1 bubble. `rs*_used`=0 with the same field → no bubble.
- **Memory wait:** MA load with `dmem_ready` low 3 cycles → `pipe_en`/`pc_en`/`ifid_en`=0 for 3 cycles, no flushes, scoreboard unchanged. Concurrent `branch_taken` gives `pc_sel`=0 until released.
- **Timeout and reset:** `MEM_TIMEOUT`=4 and `dmem_ready` held low 6 cycles → `mem_err`=1 after the 4th wait cycle and stays 1. Asserting `rst` mid-wait clears `mem_err` and enters INIT.
